io_bus_ctrl: RTL and testbench

Sequencer for memory-mapped I/O accesses in the single-cycle RISC-V core. When the control unit flags an I/O load or store (address high bits all ones), this block stalls the core and decodes the low address bits to one of four peripherals: switches, LEDs, seven-segment display and UART. It then runs a request/acknowledge handshake with a bounded wait and returns read data to the write-back mux. It sits between the control/ALU stage and the peripheral bus.

---
 rtl/io_bus_pkg.sv | 41 ++++
 rtl/io_bus_ctrl_decode.sv | 23 ++
 rtl/io_bus_ctrl.sv | 141 ++++++++++++++
 tb/tb_io_bus_ctrl.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/io_bus_pkg.sv
// Shared types and constants for the memory-mapped I/O bus sequencer.
package io_bus_pkg;

    // Sequencer states, 2-bit encoding
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam int unsigned NUM_DEV = 4;
    localparam int unsigned DATA_W  = 32;
    localparam int unsigned PAGE_W  = 6;
    localparam int unsigned CNT_W   = 8;

    // Device indices into dev_sel / dev_ack / dev_rdata
    localparam int unsigned DEV_SW   = 0;
    localparam int unsigned DEV_LED  = 1;
    localparam int unsigned DEV_SEG  = 2;
    localparam int unsigned DEV_UART = 3;

    // Address-map pages for addr[9:4]
    localparam logic [PAGE_W-1:0] PAGE_SW   = 6'h00;
    localparam logic [PAGE_W-1:0] PAGE_LED  = 6'h01;
    localparam logic [PAGE_W-1:0] PAGE_SEG  = 6'h02;
    localparam logic [PAGE_W-1:0] PAGE_UART = 6'h03;

    localparam int unsigned TIMEOUT_DEFAULT = 15;

    // One-hot device select to binary index (0 when no bit is set)
    function automatic logic [1:0] onehot_to_idx(input logic [NUM_DEV-1:0] oh);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = 0; i < int'(NUM_DEV); i++) begin
            if (oh[i]) idx = 2'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/io_bus_ctrl_decode.sv
// Page decoder: maps addr[9:4] to a one-hot device select and a mapped flag.
module io_addr_decode
    import io_bus_pkg::*;
(
    input  logic [PAGE_W-1:0]  i_page,
    output logic [NUM_DEV-1:0] o_onehot,
    output logic               o_mapped
);

    // Combinational page lookup; unmapped pages give an all-zero select
    always_comb begin
        o_onehot = '0;
        case (i_page)
            PAGE_SW:   o_onehot = NUM_DEV'(1) << DEV_SW;
            PAGE_LED:  o_onehot = NUM_DEV'(1) << DEV_LED;
            PAGE_SEG:  o_onehot = NUM_DEV'(1) << DEV_SEG;
            PAGE_UART: o_onehot = NUM_DEV'(1) << DEV_UART;
            default:   o_onehot = '0;
        endcase
        o_mapped = |o_onehot;
    end

endmodule

// File: rtl/io_bus_ctrl.sv
// I/O access sequencer: stalls the core, runs a req/ack handshake with a
// bounded wait against the selected peripheral and returns load data.
module io_bus_ctrl
    import io_bus_pkg::*;
#(
    parameter int unsigned ADDR_W  = 10,
    parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
)(
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  io_read,
    input  logic                  io_write,
    input  logic [ADDR_W-1:0]     addr,
    input  logic [31:0]           wdata,
    output logic                  stall,
    output logic [31:0]           rdata,
    output logic                  rdata_valid,
    output logic                  bus_err,
    output logic [3:0]            dev_sel,
    output logic                  dev_req,
    output logic                  dev_we,
    output logic [3:0]            dev_addr,
    output logic [31:0]           dev_wdata,
    input  logic [3:0]            dev_ack,
    input  logic [127:0]          dev_rdata
);

    state_t              r_state;
    logic [CNT_W-1:0]    r_cnt;
    logic [1:0]          r_dev_idx;
    logic [31:0]         r_rdata;
    logic                r_rdata_valid;
    logic                r_bus_err;
    logic [NUM_DEV-1:0]  r_dev_sel;
    logic                r_dev_req;
    logic                r_dev_we;
    logic [3:0]          r_dev_addr;
    logic [31:0]         r_dev_wdata;

    logic [NUM_DEV-1:0]  w_onehot;
    logic                w_mapped;
    logic                w_access;
    logic                w_ack;
    logic                w_tmo;
    logic [DATA_W-1:0]   w_sel_rdata;

    io_addr_decode u_decode (
        .i_page   (PAGE_W'(addr[ADDR_W-1:4])),
        .o_onehot (w_onehot),
        .o_mapped (w_mapped)
    );

    // Handshake qualifiers: only the selected device's ack counts
    assign w_access    = io_read | io_write;
    assign w_ack       = |(dev_ack & r_dev_sel);
    assign w_tmo       = (r_state == ST_WAIT) && ((32'(r_cnt) + 32'd1) == TIMEOUT);
    assign w_sel_rdata = dev_rdata[{r_dev_idx, 5'd0} +: DATA_W];

    // Stall covers the request cycle in IDLE plus the whole handshake
    assign stall = ((r_state == ST_IDLE) && w_access)
                 || (r_state == ST_REQ) || (r_state == ST_WAIT);

    // Sequencer state, timeout counter and registered outputs
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_cnt         <= '0;
            r_dev_idx     <= '0;
            r_rdata       <= '0;
            r_rdata_valid <= 1'b0;
            r_bus_err     <= 1'b0;
            r_dev_sel     <= '0;
            r_dev_req     <= 1'b0;
            r_dev_we      <= 1'b0;
            r_dev_addr    <= '0;
            r_dev_wdata   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_rdata_valid <= 1'b0;
                    if (w_access) begin
                        // Simultaneous load+store is executed as a store but flagged
                        if (io_read && io_write) r_bus_err <= 1'b1;
                        if (w_mapped) begin
                            r_dev_sel   <= w_onehot;
                            r_dev_idx   <= onehot_to_idx(w_onehot);
                            r_dev_we    <= io_write;
                            r_dev_addr  <= addr[3:0];
                            r_dev_wdata <= wdata;
                            r_dev_req   <= 1'b1;
                            r_state     <= ST_REQ;
                        end else begin
                            r_rdata       <= '0;
                            r_bus_err     <= 1'b1;
                            r_rdata_valid <= 1'b1;
                            r_state       <= ST_DONE;
                        end
                    end
                end

                ST_REQ, ST_WAIT: begin
                    if (w_ack || w_tmo) begin
                        // Ack beats a coincident timeout
                        r_rdata       <= (w_ack && !r_dev_we) ? w_sel_rdata : '0;
                        if (!w_ack) r_bus_err <= 1'b1;
                        r_rdata_valid <= 1'b1;
                        r_dev_sel     <= '0;
                        r_dev_req     <= 1'b0;
                        r_dev_we      <= 1'b0;
                        r_dev_addr    <= '0;
                        r_dev_wdata   <= '0;
                        r_state       <= ST_DONE;
                    end else if (r_state == ST_REQ) begin
                        r_cnt   <= '0;
                        r_state <= ST_WAIT;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end

                ST_DONE: begin
                    // Retiring instruction's flags are still present; ignore them
                    r_rdata_valid <= 1'b0;
                    r_state       <= ST_IDLE;
                end

                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign rdata       = r_rdata;
    assign rdata_valid = r_rdata_valid;
    assign bus_err     = r_bus_err;
    assign dev_sel     = r_dev_sel;
    assign dev_req     = r_dev_req;
    assign dev_we      = r_dev_we;
    assign dev_addr    = r_dev_addr;
    assign dev_wdata   = r_dev_wdata;

endmodule

// File: tb/tb_io_bus_ctrl.sv
// Directed bench for io_bus_ctrl with a latency-programmable device model
// and a scoreboard of expected completions.
module tb_io_bus_ctrl;

    logic          clock = 1'b0;
    logic          reset;
    logic          io_read, io_write;
    logic [9:0]    addr;
    logic [31:0]   wdata;
    logic          stall;
    logic [31:0]   rdata;
    logic          rdata_valid;
    logic          bus_err;
    logic [3:0]    dev_sel;
    logic          dev_req;
    logic          dev_we;
    logic [3:0]    dev_addr;
    logic [31:0]   dev_wdata;
    logic [3:0]    dev_ack;
    logic [127:0]  dev_rdata;

    localparam logic [31:0] D_SW   = 32'h0000_00A5;
    localparam logic [31:0] D_LED  = 32'h1234_5678;
    localparam logic [31:0] D_SEG  = 32'hDEAD_BEEF;
    localparam logic [31:0] D_UART = 32'hCAFE_0042;

    int checks   = 0;
    int failures = 0;

    // Device model controls
    logic        resp_en   = 1'b0;
    int          resp_dev  = 0;
    int          resp_lat  = 0;
    logic [3:0]  extra_ack = 4'b0000;
    int          req_cnt   = 0;
    logic        model_err = 1'b0;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } exp_t;
    exp_t sb[$];

    io_bus_ctrl dut (
        .clock       (clock),
        .reset       (reset),
        .io_read     (io_read),
        .io_write    (io_write),
        .addr        (addr),
        .wdata       (wdata),
        .stall       (stall),
        .rdata       (rdata),
        .rdata_valid (rdata_valid),
        .bus_err     (bus_err),
        .dev_sel     (dev_sel),
        .dev_req     (dev_req),
        .dev_we      (dev_we),
        .dev_addr    (dev_addr),
        .dev_wdata   (dev_wdata),
        .dev_ack     (dev_ack),
        .dev_rdata   (dev_rdata)
    );

    always #5 clock = ~clock;

    assign dev_rdata = {D_UART, D_SEG, D_LED, D_SW};

    // Cycles the request has been held so far (0 in the REQ cycle)
    always @(posedge clock) begin
        if (reset || dev_req !== 1'b1) req_cnt <= 0;
        else                            req_cnt <= req_cnt + 1;
    end

    always_comb begin
        dev_ack = extra_ack;
        if (resp_en && dev_req === 1'b1 && req_cnt == resp_lat)
            dev_ack = dev_ack | (4'b0001 << resp_dev);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every completion pulse must match the oldest expectation
    always @(negedge clock) begin
        if (rdata_valid === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $error("FAIL sb_unexpected observed=%h expected=none", rdata);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("sb_rdata", rdata, e.rdata);
                chk("sb_bus_err", 32'(bus_err), 32'(e.err));
            end
        end
    end

    // One access from the IDLE cycle through completion; called at posedge+1
    task automatic do_access(input logic rd, input logic wr, input logic [9:0] a,
                             input logic [31:0] wd, input logic [3:0] exp_sel,
                             input logic [31:0] exp_rd, input logic err_now,
                             input int exp_stall);
        int   n;
        int   cyc;
        exp_t e;
        model_err = model_err | err_now;
        e.rdata = exp_rd;
        e.err   = model_err;
        sb.push_back(e);
        io_read = rd; io_write = wr; addr = a; wdata = wd;
        #1;
        n = 0; cyc = 0;
        while (rdata_valid !== 1'b1 && cyc < 60) begin
            if (stall === 1'b1) n++;
            if (exp_sel == 4'b0000) begin
                chk("unmapped_no_req", 32'(dev_req), 32'd0);
            end else if (dev_req === 1'b1) begin
                chk("req_sel", 32'(dev_sel), 32'(exp_sel));
                chk("req_we", 32'(dev_we), 32'(wr));
                chk("req_addr", 32'(dev_addr), 32'(a[3:0]));
                chk("req_wdata", dev_wdata, wd);
            end
            @(posedge clock); #2;
            cyc++;
        end
        chk("completion_within_bound", 32'(rdata_valid), 32'd1);
        chk("stall_cycles", 32'(n), 32'(exp_stall));
        chk("done_stall_low", 32'(stall), 32'd0);
        chk("done_sel_clear", 32'(dev_sel), 32'd0);
        chk("done_req_clear", 32'(dev_req), 32'd0);
        @(posedge clock); #1;
        io_read = 1'b0; io_write = 1'b0;
        #1;
        chk("valid_one_cycle", 32'(rdata_valid), 32'd0);
        chk("rdata_hold", rdata, exp_rd);
        chk("bus_err_hold", 32'(bus_err), 32'(model_err));
        @(posedge clock); #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_stall"}, 32'(stall), 32'd0);
        chk({tag, "_rdata"}, rdata, 32'd0);
        chk({tag, "_valid"}, 32'(rdata_valid), 32'd0);
        chk({tag, "_err"}, 32'(bus_err), 32'd0);
        chk({tag, "_sel"}, 32'(dev_sel), 32'd0);
        chk({tag, "_req"}, 32'(dev_req), 32'd0);
        chk({tag, "_we"}, 32'(dev_we), 32'd0);
        chk({tag, "_addr"}, 32'(dev_addr), 32'd0);
        chk({tag, "_wdata"}, dev_wdata, 32'd0);
    endtask

    initial begin
        reset = 1'b1; io_read = 1'b0; io_write = 1'b0; addr = '0; wdata = '0;
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        #1 check_reset_outputs("por");
        @(posedge clock); #1;

        // Zero-wait switch read
        resp_en = 1'b1; resp_dev = 0; resp_lat = 0;
        do_access(1'b1, 1'b0, 10'h000, 32'h0, 4'b0001, D_SW, 1'b0, 2);

        // LED write acked after three WAIT cycles
        resp_dev = 1; resp_lat = 3;
        do_access(1'b0, 1'b1, 10'h010, 32'h0000_FFFF, 4'b0010, 32'h0, 1'b0, 5);

        // Foreign ack ignored; LED ack coincides with the timeout and wins
        resp_dev = 1; resp_lat = 15; extra_ack = 4'b0100;
        do_access(1'b1, 1'b0, 10'h012, 32'h0, 4'b0010, D_LED, 1'b0, 17);
        extra_ack = 4'b0000;

        // UART read with no ack times out
        resp_en = 1'b0;
        do_access(1'b1, 1'b0, 10'h030, 32'h0, 4'b1000, 32'h0, 1'b1, 17);

        // Error flag stays set across a clean access
        resp_en = 1'b1; resp_dev = 2; resp_lat = 0;
        do_access(1'b1, 1'b0, 10'h025, 32'h0, 4'b0100, D_SEG, 1'b0, 2);

        // Reset in the second WAIT cycle aborts the access
        resp_dev = 0; resp_lat = 10;
        io_read = 1'b1; addr = 10'h000;
        @(posedge clock); #2;
        @(posedge clock); #2;
        @(posedge clock); #2;
        chk("midop_req_active", 32'(dev_req), 32'd1);
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0; io_read = 1'b0;
        model_err = 1'b0;
        #1 check_reset_outputs("midop");
        @(posedge clock); #1;

        // Fresh switch read after the abort
        resp_lat = 0;
        do_access(1'b1, 1'b0, 10'h003, 32'h0, 4'b0001, D_SW, 1'b0, 2);

        // Unmapped page
        do_access(1'b1, 1'b0, 10'h3F0, 32'h0, 4'b0000, 32'h0, 1'b1, 1);

        // Clear the error, then issue load and store together to the LED
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0; model_err = 1'b0;
        #1 chk("err_cleared", 32'(bus_err), 32'd0);
        @(posedge clock); #1;
        resp_dev = 1; resp_lat = 0;
        do_access(1'b1, 1'b1, 10'h014, 32'h0BAD_F00D, 4'b0010, 32'h0, 1'b1, 2);

        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
